// File: rtl/fifo_port_sched.sv
// Shares one external FIFO between NREQ round-robin write requesters and
// drains its read side onto a valid/ready output through a hold register.
module fifo_port_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [IDW-1:0]    grant_id,
  output logic              fifo_wn,
  output logic [W-1:0]      fifo_din,
  input  logic              fifo_full,
  output logic              fifo_rn,
  input  logic [W-1:0]      fifo_dout,
  input  logic              fifo_empty,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  input  logic              out_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic           grant;

  logic [1:0]     state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           read_req;

  // Search starts at the pointer and wraps, so the first valid hit is the winner.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign grant    = found && !fifo_full && !reset;
  assign fifo_wn  = grant;
  assign grant_id = winner;
  assign fifo_din = req_data[int'(winner) * W +: W];

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + IDW'(1);
    end
  end

  // Output is always empty while a read is in flight; out_valid drops on hand-off.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    read_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          read_req = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        out_data_d  = fifo_dout;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            read_req = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign fifo_rn   = read_req && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
